// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared state encoding and rotate helper for the round-robin arbiter
package arb_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_BUSY = 1'b1;

  localparam int MAX_N = 32;

  // Rotate the low n bits of vec right by amt (amt < n); bits at and above n read as 0.
  function automatic logic [MAX_N-1:0] rotr(input logic [MAX_N-1:0] vec, input int amt, input int n);
    logic [MAX_N-1:0] r;
    int j;
    r = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) begin
        j = i + amt;
        if (j >= n) j = j - n;
        r[i[4:0]] = vec[j[4:0]];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_lsb_encoder.sv
// rtl/rr_lsb_encoder.sv - combinational lowest-set-bit priority encoder
module rr_lsb_encoder #(
  parameter int N = 4
) (
  input  logic [N-1:0]         in,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int W = $clog2(N);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in[i]) begin
        idx = W'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - round-robin arbiter with one-hot registered grant and hold limit
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 timeout
);

  localparam int W  = $clog2(N);
  localparam int CW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);
  localparam logic [N-1:0]  ONE       = {{(N-1){1'b0}}, 1'b1};

  logic          state, state_n;
  logic [W-1:0]  ptr, ptr_n;
  logic [CW-1:0] hold_cnt, hold_n;
  logic [N-1:0]  gnt_n;
  logic [W-1:0]  gnt_id_n;
  logic          timeout_n;

  logic [N-1:0]  rot;
  logic [W-1:0]  enc_idx;
  logic          enc_any;
  logic [W:0]    sum;
  logic [W-1:0]  winner;

  assign rot = N'(rotr(MAX_N'(req), int'(ptr), N));

  rr_lsb_encoder #(.N(N)) u_enc (
    .in  (rot),
    .idx (enc_idx),
    .any (enc_any)
  );

  // Undo the rotation: the encoder index is relative to ptr.
  assign sum    = {1'b0, ptr} + {1'b0, enc_idx};
  assign winner = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : W'(sum);

  assign busy = |gnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      gnt_id   <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      gnt      <= gnt_n;
      gnt_id   <= gnt_id_n;
      timeout  <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    hold_n    = hold_cnt;
    gnt_n     = gnt;
    gnt_id_n  = gnt_id;
    timeout_n = 1'b0;
    case (state)
      ST_IDLE: begin
        gnt_n    = '0;
        gnt_id_n = '0;
        if (enc_any) begin
          state_n  = ST_BUSY;
          gnt_n    = ONE << winner;
          gnt_id_n = winner;
          hold_n   = '0;
        end
      end
      default: begin
        // done or a dropped request takes precedence over the hold limit.
        if (done || !(|(req & gnt)) || (hold_cnt == HOLD_LAST)) begin
          state_n   = ST_IDLE;
          gnt_n     = '0;
          gnt_id_n  = '0;
          ptr_n     = (gnt_id == W'(N - 1)) ? '0 : gnt_id + 1'b1;
          timeout_n = !done && (|(req & gnt));
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// tb/tb_rr_grant_arbiter.sv - directed self-checking bench for rr_grant_arbiter
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = '0;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  logic [2:0] req3 = '0;
  logic       done3 = 1'b0;
  logic [2:0] gnt3;
  logic [1:0] gnt_id3;
  logic       busy3;
  logic       timeout3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_grant_arbiter #(.N(4), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  rr_grant_arbiter #(.N(3), .MAX_HOLD(16)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .done(done3),
    .gnt(gnt3), .gnt_id(gnt_id3), .busy(busy3), .timeout(timeout3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_seq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [2:0] seq3 [3]    = '{3'b100, 3'b001, 3'b010};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset_gnt", 32'(gnt), 32'h0);
    check("reset_id", 32'(gnt_id), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_timeout", 32'(timeout), 32'h0);

    // rotation with all requesters active
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("rot_gnt%0d", k), 32'(gnt), 32'(rot_seq[k]));
      check($sformatf("rot_busy%0d", k), 32'(busy), 32'h1);
      done = 1'b1;
      tick();
      done = 1'b0;
      check($sformatf("rot_idle%0d", k), 32'(gnt), 32'h0);
    end
    req = 4'b0000;

    // timeout after four cycles of holding
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold_gnt%0d", k), 32'(gnt), 32'h4);
      check($sformatf("hold_to%0d", k), 32'(timeout), 32'h0);
    end
    tick();
    check("to_gnt", 32'(gnt), 32'h0);
    check("to_pulse", 32'(timeout), 32'h1);
    tick();
    check("regrant_gnt", 32'(gnt), 32'h4);
    check("regrant_to", 32'(timeout), 32'h0);

    // done coincides with the hold limit
    tick();
    tick();
    tick();
    check("coin_pre", 32'(gnt), 32'h4);
    done = 1'b1;
    tick();
    done = 1'b0;
    check("coin_gnt", 32'(gnt), 32'h0);
    check("coin_to", 32'(timeout), 32'h0);

    // request drop releases; ptr then sits at 3
    tick();
    check("drop_pre_gnt", 32'(gnt), 32'h4);
    check("drop_pre_id", 32'(gnt_id), 32'h2);
    req = 4'b0000;
    tick();
    check("drop_gnt", 32'(gnt), 32'h0);
    check("drop_to", 32'(timeout), 32'h0);
    req = 4'b1001;
    tick();
    check("after_drop_gnt", 32'(gnt), 32'h8);
    check("after_drop_id", 32'(gnt_id), 32'h3);

    // asynchronous reset mid-grant
    #2;
    rst = 1'b1;
    #1;
    check("arst_gnt", 32'(gnt), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_id", 32'(gnt_id), 32'h0);
    tick();
    rst = 1'b0;
    req = 4'b1000;
    tick();
    check("post_rst_gnt", 32'(gnt), 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1001;
    tick();
    check("post_rst_ptr0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();

    // N=3: move ptr to 2, then observe 2 -> 0 -> 1 with wrap
    req3 = 3'b010;
    tick();
    check("n3_setup", 32'(gnt3), 32'h2);
    done3 = 1'b1;
    tick();
    done3 = 1'b0;
    req3 = 3'b111;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("n3_gnt%0d", k), 32'(gnt3), 32'(seq3[k]));
      done3 = 1'b1;
      tick();
      done3 = 1'b0;
      check($sformatf("n3_idle%0d", k), 32'(gnt3), 32'h0);
    end
    req3 = 3'b000;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // one-hot invariant on every cycle
  always @(negedge clk) begin
    if (!rst && ($countones(gnt) > 1 || $countones(gnt3) > 1)) begin
      check("onehot", 32'(gnt), 32'h0);
    end
  end

endmodule
